multicycle_sll: RTL

MULTICYCLE_SLL -- requirements
Module: multicycle_sll

---
 rtl/multicycle_sll.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sll.sv
// ----------------------------------------------------------------------------
// multicycle_sll
//
// Purpose:
//   32-bit logical left shifter built as a five-stage iterative barrel shifter.
//   One operand is accepted per operation. Each SHIFT cycle applies one stage
//   of 2^k bits (k = 0..4). Stage k is applied only when bit k of the captured
//   shift amount is set. The overflow flag collects every 1 bit that is pushed
//   past bit 31.
//
// Ports:
//   clock    in   1   rising-edge system clock
//   reset_n  in   1   asynchronous active-low reset
//   start    in   1   request a shift; only sampled in IDLE
//   in       in  32   operand, captured when start is accepted
//   sh_amt   in   5   unsigned left-shift amount, captured with the operand
//   out      out 32   working register: in << sh_amt, valid while done=1 and
//                     held in IDLE until the next accept
//   ovf      out  1   a 1 bit was shifted out past bit 31
//   busy     out  1   high while in SHIFT
//   done     out  1   one-cycle pulse, high only in DONE
//
// Configuration:
//   SLL_ZERO_SKIP_EN  when defined, an accept with sh_amt=0 goes straight from
//                     IDLE to DONE. When undefined, every operation takes the
//                     full five SHIFT cycles, including sh_amt=0.
//
// Timing (accept at edge t):
//   edges t+1..t+5 apply stages 0..4; DONE after t+5; IDLE again at t+6.
// ----------------------------------------------------------------------------
module multicycle_sll (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [4:0]  sh_amt,
    output logic [31:0] out,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [2:0] LastStage = 3'd4;

    state_e      r_state;
    state_e      w_state_next;
    logic [2:0]  r_k;
    logic [2:0]  w_k_next;
    logic [31:0] r_work;
    logic [31:0] w_work_next;
    logic [4:0]  r_amt;
    logic [4:0]  w_amt_next;
    logic        r_ovf;
    logic        w_ovf_next;

    // Result of the stage selected by r_k, before qualification by r_amt[k].
    logic        w_stage_en;
    logic [31:0] w_stage_shifted;
    logic        w_stage_lost;

    // ------------------------------------------------------------------------
    // Stage decode: stage k shifts by 2^k, and the 2^k MSBs of the working
    // register are the bits that fall off the top.
    // ------------------------------------------------------------------------
    always_comb begin
        w_stage_en      = 1'b0;
        w_stage_shifted = r_work;
        w_stage_lost    = 1'b0;
        case (r_k)
            3'd0: begin
                w_stage_en      = r_amt[0];
                w_stage_shifted = {r_work[30:0], 1'b0};
                w_stage_lost    = r_work[31];
            end
            3'd1: begin
                w_stage_en      = r_amt[1];
                w_stage_shifted = {r_work[29:0], 2'b0};
                w_stage_lost    = |r_work[31:30];
            end
            3'd2: begin
                w_stage_en      = r_amt[2];
                w_stage_shifted = {r_work[27:0], 4'b0};
                w_stage_lost    = |r_work[31:28];
            end
            3'd3: begin
                w_stage_en      = r_amt[3];
                w_stage_shifted = {r_work[23:0], 8'b0};
                w_stage_lost    = |r_work[31:24];
            end
            3'd4: begin
                w_stage_en      = r_amt[4];
                w_stage_shifted = {r_work[15:0], 16'b0};
                w_stage_lost    = |r_work[31:16];
            end
            default: begin
                w_stage_en      = 1'b0;
                w_stage_shifted = r_work;
                w_stage_lost    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_work_next  = r_work;
        w_amt_next   = r_amt;
        w_ovf_next   = r_ovf;

        case (r_state)
            StIdle: begin
                // out/ovf keep the last result here until a new accept.
                if (start) begin
                    w_work_next = in;
                    w_amt_next  = sh_amt;
                    w_ovf_next  = 1'b0;
                    w_k_next    = 3'd0;
`ifdef SLL_ZERO_SKIP_EN
                    if (sh_amt == 5'd0) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StShift;
                    end
`else
                    w_state_next = StShift;
`endif
                end
            end

            StShift: begin
                if (w_stage_en) begin
                    w_work_next = w_stage_shifted;
                    w_ovf_next  = r_ovf | w_stage_lost;
                end
                if (r_k == LastStage) begin
                    w_k_next     = 3'd0;
                    w_state_next = StDone;
                end else begin
                    w_k_next = r_k + 3'd1;
                end
            end

            StDone: begin
                w_state_next = StIdle;
            end

            default: begin
                w_state_next = StIdle;
                w_k_next     = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_k     <= 3'd0;
            r_work  <= 32'h0;
            r_amt   <= 5'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
            r_work  <= w_work_next;
            r_amt   <= w_amt_next;
            r_ovf   <= w_ovf_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all taken directly from registers
    // ------------------------------------------------------------------------
    always_comb begin
        out  = r_work;
        ovf  = r_ovf;
        busy = (r_state == StShift);
        done = (r_state == StDone);
    end

endmodule
